// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus responder and its work RAM.
package cpu_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam logic [ADDR_W-1:0] DEFAULT_RAM_REGION_END = 16'h1FFF;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    RESPOND,
    RELEASE
  } state_t;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port byte RAM, synchronous read and write; read data appears one edge after the access.
module ram_sp_sync #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_bus_responder.sv
// Responder side of the CPU bus: mirrored work RAM below RAM_REGION_END, open-bus
// behaviour above it, one access per address_valid_i high period.
module cpu_bus_responder
  import cpu_bus_pkg::*;
#(
  parameter int                RAM_ADDR_BITS  = 11,
  parameter logic [ADDR_W-1:0] RAM_REGION_END = DEFAULT_RAM_REGION_END,
  parameter int                READ_LATENCY   = 2
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              address_valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              unmapped_o
);

  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t            r_state, w_state_next;
  logic [3:0]        r_cnt, w_cnt_next;
  logic              r_data_valid, w_data_valid_next;
  logic [DATA_W-1:0] r_data, w_data_next;
  logic [DATA_W-1:0] r_open_bus, w_open_bus_next;
  logic              r_unmapped, w_unmapped_next;
  logic              r_mapped, w_mapped_next;

  logic              w_accept;
  logic              w_addr_mapped;
  logic              w_ram_en;
  logic [DATA_W-1:0] w_ram_rdata;
  logic [DATA_W-1:0] w_resp;

  assign w_addr_mapped = (address_i <= RAM_REGION_END);
  assign w_accept      = (r_state == IDLE) && address_valid_i;
  // The RAM is touched only on the accept edge, so its output stays put for the whole response.
  assign w_ram_en      = w_accept && w_addr_mapped;
  assign w_resp        = r_mapped ? w_ram_rdata : r_open_bus;

  ram_sp_sync #(
    .ADDR_W (RAM_ADDR_BITS),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (clock_i),
    .i_en    (w_ram_en),
    .i_we    (data_valid_i),
    .i_addr  (address_i[RAM_ADDR_BITS-1:0]),
    .i_wdata (data_i),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_data_valid_next = r_data_valid;
    w_data_next       = r_data;
    w_open_bus_next   = r_open_bus;
    w_unmapped_next   = 1'b0;
    w_mapped_next     = r_mapped;

    case (r_state)
      IDLE: begin
        if (address_valid_i) begin
          w_mapped_next   = w_addr_mapped;
          w_unmapped_next = !w_addr_mapped;
          if (data_valid_i) begin
            w_open_bus_next = data_i;
            w_state_next    = RELEASE;
          end else begin
            w_cnt_next   = LAT_M1;
            w_state_next = (READ_LATENCY == 1) ? RESPOND : READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_next = RESPOND;
        end
      end
      RESPOND: begin
        // First cycle always presents data, even if the CPU already let go of valid.
        if (!r_data_valid) begin
          w_data_valid_next = 1'b1;
          w_data_next       = w_resp;
          w_open_bus_next   = w_resp;
        end else if (!address_valid_i) begin
          w_data_valid_next = 1'b0;
          w_state_next      = IDLE;
        end
      end
      RELEASE: begin
        if (!address_valid_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_data_valid <= 1'b0;
      r_data       <= '0;
      r_open_bus   <= '0;
      r_unmapped   <= 1'b0;
      r_mapped     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_data_valid <= w_data_valid_next;
      r_data       <= w_data_next;
      r_open_bus   <= w_open_bus_next;
      r_unmapped   <= w_unmapped_next;
      r_mapped     <= w_mapped_next;
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_data_valid;
  assign unmapped_o   = r_unmapped;

endmodule
